// File: rtl/store_sequencer_if.sv
// store_sequencer_if: store request handshake and dmem write port bundle
interface store_sequencer_if #(parameter int ADDR_W = 14);
  logic req_valid;
  logic req_ready;
  logic [31:0] req_addr;
  logic [1:0] req_size;
  logic [31:0] req_data;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0] dmem_we;
  logic [31:0] dmem_din;
  logic done;
  logic misalign;
  logic illegal;
  modport master (
    output req_valid, req_addr, req_size, req_data,
    input req_ready, dmem_addr, dmem_we, dmem_din, done, misalign, illegal
  );
  modport slave (
    input req_valid, req_addr, req_size, req_data,
    output req_ready, dmem_addr, dmem_we, dmem_din, done, misalign, illegal
  );
endinterface

// File: rtl/store_sequencer.sv
// store_sequencer: splits CPU stores into registered dmem write beats; STORE_SPLIT_EN enables the second beat of word-crossing stores
module store_sequencer #(parameter int ADDR_W = 14) (
  input logic clk,
  input logic rst,
  store_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state, state_nx;
  logic cross_q, split_q, illegal_q, accept, load;
  logic [1:0] off;
  logic [3:0] mask;
  logic [7:0] wide;
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
  assign off = bus.req_addr[1:0];
  assign mask = bus.req_size == 2'd0 ? 4'b0001 : bus.req_size == 2'd1 ? 4'b0011 : 4'b1111;
  assign wide = {4'b0, mask} << off;
  assign accept = bus.req_valid && bus.req_ready;
  assign load = accept && bus.req_size != 2'd3;
`ifdef STORE_SPLIT_EN
  logic [63:0] wdata;
  logic [3:0] pend_we;
  logic [31:0] pend_din;
  assign wdata = {32'b0, bus.req_data} << {off, 3'b000};
  assign split_q = cross_q;
  // upper half of a crossing store, replayed on the HI beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_we <= 4'b0;
      pend_din <= 32'b0;
    end else if (load) begin
      pend_we <= wide[7:4];
      pend_din <= wdata[63:32];
    end
`else
  logic [31:0] wdata;
  assign wdata = bus.req_data << {off, 3'b000};
  assign split_q = 1'b0;
`endif
  assign bus.req_ready = state != LO || !split_q;
  assign bus.done = (state == LO && !split_q) || state == HI;
  assign bus.misalign = state == LO && cross_q;
  assign bus.illegal = illegal_q;
  // next state: a split LO beat always continues to HI, otherwise any legal accept issues a LO beat
  always_comb begin
    state_nx = IDLE;
    state_nx = state == LO && split_q ? HI : load ? LO : IDLE;
  end
  // state and registered write port; dmem_din/dmem_addr hold while no beat is issued
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cross_q <= 1'b0;
      illegal_q <= 1'b0;
      bus.dmem_addr <= '0;
      bus.dmem_we <= 4'b0;
      bus.dmem_din <= 32'b0;
    end else begin
      state <= state_nx;
      illegal_q <= accept && bus.req_size == 2'd3;
      if (load) begin
        bus.dmem_addr <= bus.req_addr[ADDR_W+1:2];
        bus.dmem_we <= wide[3:0];
        bus.dmem_din <= wdata[31:0];
        cross_q <= |wide[7:4];
      end
`ifdef STORE_SPLIT_EN
      else if (state == LO && split_q) begin
        bus.dmem_addr <= bus.dmem_addr + ADDR_W'(1);
        bus.dmem_we <= pend_we;
        bus.dmem_din <= pend_din;
      end
`endif
      else bus.dmem_we <= 4'b0;
    end
endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: directed checks of store_sequencer beats, handshake, illegal size and reset
module tb_store_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  store_sequencer_if #(.ADDR_W(14)) bus ();
  store_sequencer #(.ADDR_W(14)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_size = s;
    bus.req_data = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] we, input logic [31:0] din);
    chk({tag, "_addr"}, 32'(bus.dmem_addr), a);
    chk({tag, "_we"}, 32'(bus.dmem_we), 32'(we));
    chk({tag, "_din"}, bus.dmem_din, din);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_size = 2'd0;
    bus.req_data = 32'h0;
    tick();
    tick();
    beat("rst", 32'h0, 4'h0, 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_misalign", 32'(bus.misalign), 32'h0);
    chk("rst_illegal", 32'(bus.illegal), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    rst = 1'b0;
    tick();
    req(32'h100, 2'd2, 32'hDEADBEEF);
    tick();
    bus.req_valid = 1'b0;
    beat("word", 32'h40, 4'hF, 32'hDEADBEEF);
    chk("word_done", 32'(bus.done), 32'h1);
    chk("word_misalign", 32'(bus.misalign), 32'h0);
    tick();
    chk("idle_we", 32'(bus.dmem_we), 32'h0);
    chk("idle_din_hold", bus.dmem_din, 32'hDEADBEEF);
    chk("idle_done", 32'(bus.done), 32'h0);
    req(32'h102, 2'd0, 32'h000000FF);
    tick();
    req(32'h101, 2'd1, 32'h00003CC3);
    beat("byte", 32'h40, 4'b0100, 32'h00FF0000);
    chk("byte_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    beat("half", 32'h40, 4'b0110, 32'h003CC300);
    chk("half_ready", 32'(bus.req_ready), 32'h1);
    chk("half_done", 32'(bus.done), 32'h1);
    tick();
    chk("idle2_we", 32'(bus.dmem_we), 32'h0);
    req(32'h103, 2'd2, 32'h11223344);
    tick();
    bus.req_valid = 1'b0;
    beat("split_lo", 32'h40, 4'b1000, 32'h44000000);
    chk("split_lo_misalign", 32'(bus.misalign), 32'h1);
`ifdef STORE_SPLIT_EN
    chk("split_lo_ready", 32'(bus.req_ready), 32'h0);
    chk("split_lo_done", 32'(bus.done), 32'h0);
    tick();
    beat("split_hi", 32'h41, 4'b0111, 32'h00112233);
    chk("split_hi_done", 32'(bus.done), 32'h1);
    chk("split_hi_misalign", 32'(bus.misalign), 32'h0);
    chk("split_hi_ready", 32'(bus.req_ready), 32'h1);
`else
    chk("split_lo_ready", 32'(bus.req_ready), 32'h1);
    chk("split_lo_done", 32'(bus.done), 32'h1);
`endif
    tick();
    chk("split_end_we", 32'(bus.dmem_we), 32'h0);
    req(32'hFFFF, 2'd1, 32'h0000ABCD);
    tick();
    bus.req_valid = 1'b0;
    beat("wrap_lo", 32'h3FFF, 4'b1000, 32'hCD000000);
`ifdef STORE_SPLIT_EN
    tick();
    beat("wrap_hi", 32'h0, 4'b0001, 32'h000000AB);
`endif
    tick();
    chk("wrap_end_we", 32'(bus.dmem_we), 32'h0);
    req(32'h200, 2'd3, 32'h55);
    tick();
    bus.req_valid = 1'b0;
    chk("ill_we", 32'(bus.dmem_we), 32'h0);
    chk("ill_flag", 32'(bus.illegal), 32'h1);
    chk("ill_done", 32'(bus.done), 32'h0);
    chk("ill_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("ill_clear", 32'(bus.illegal), 32'h0);
    req(32'h200, 2'd3, 32'h55);
    tick();
    req(32'h204, 2'd2, 32'h12345678);
    chk("ill2_flag", 32'(bus.illegal), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    beat("after_ill", 32'h81, 4'hF, 32'h12345678);
    chk("after_ill_illegal", 32'(bus.illegal), 32'h0);
    tick();
    req(32'h103, 2'd2, 32'h11223344);
    tick();
    bus.req_valid = 1'b0;
    chk("rs_lo_we", 32'(bus.dmem_we), 32'h8);
    #1 rst = 1'b1;
    #1;
    chk("rs_async_we", 32'(bus.dmem_we), 32'h0);
    chk("rs_async_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("rs_no_hi_we", 32'(bus.dmem_we), 32'h0);
    chk("rs_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    tick();
    chk("rs_rel_we", 32'(bus.dmem_we), 32'h0);
    chk("rs_rel_ready", 32'(bus.req_ready), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
